// File: rtl/gmii_write.sv
// GMII transmit framer: drains a show-ahead 9-bit FIFO, adds preamble/SFD, enforces IFG and timestamps the SFD.
// All wire outputs are registered (one cycle after the decision); the FIFO read strobe is combinational.
module gmii_write #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        port_enable,
    input  logic [8:0]  iv_data,
    input  logic        i_data_empty,
    output logic        o_data_rd,
    input  logic [18:0] timer,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [18:0] ov_tx_ts,
    output logic        o_ts_valid,
    output logic        o_pkt_sent_pulse,
    output logic        o_fifo_underflow_pulse,
    output logic [2:0]  report_gmii_write_state
);

    typedef enum logic [2:0] {
        idle_s    = 3'd0,
        pre_s     = 3'd1,
        data_s    = 3'd2,
        discard_s = 3'd3,
        ifg_s     = 3'd4
    } state_t;

    localparam logic [7:0] PRE_END = 8'(PREAMBLE_LEN);
    localparam logic [7:0] IFG_END = 8'(IFG_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d;
    logic        er_q, er_d;
    logic [18:0] ts_q, ts_d;
    logic        ts_vld_q, ts_vld_d;
    logic        sent_q, sent_d;
    logic        uflow_q, uflow_d;
    logic        rd_c;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= idle_s;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            txd_q    <= '0;
            en_q     <= 1'b0;
            er_q     <= 1'b0;
            ts_q     <= '0;
            ts_vld_q <= 1'b0;
            sent_q   <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            txd_q    <= txd_d;
            en_q     <= en_d;
            er_q     <= er_d;
            ts_q     <= ts_d;
            ts_vld_q <= ts_vld_d;
            sent_q   <= sent_d;
            uflow_q  <= uflow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        txd_d    = 8'h00;
        en_d     = 1'b0;
        er_d     = 1'b0;
        ts_d     = ts_q;
        ts_vld_d = 1'b0;
        sent_d   = 1'b0;
        uflow_d  = 1'b0;
        rd_c     = 1'b0;
        case (state_q)
            idle_s: begin
                if (!i_data_empty) begin
                    // A non-boundary word at rest means we lost framing; resync by draining.
                    if (!iv_data[8]) begin
                        state_d = discard_s;
                    end else if (port_enable) begin
                        state_d = pre_s;
                        cnt_d   = 8'd1;
                        en_d    = 1'b1;
                        txd_d   = 8'h55;
                    end
                end
            end
            pre_s: begin
                en_d = 1'b1;
                if (cnt_q < PRE_END) begin
                    txd_d = 8'h55;
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    txd_d    = 8'hD5;
                    ts_d     = timer;
                    ts_vld_d = 1'b1;
                    first_d  = 1'b1;
                    state_d  = data_s;
                end
            end
            data_s: begin
                en_d = 1'b1;
                if (!i_data_empty) begin
                    rd_c    = 1'b1;
                    txd_d   = iv_data[7:0];
                    first_d = 1'b0;
                    if (iv_data[8] && !first_q) begin
                        sent_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ifg_s;
                    end
                end else begin
                    er_d    = 1'b1;
                    uflow_d = 1'b1;
                    state_d = discard_s;
                end
            end
            discard_s: begin
                if (!i_data_empty) begin
                    rd_c = 1'b1;
                    if (iv_data[8]) begin
                        cnt_d   = '0;
                        state_d = ifg_s;
                    end
                end
            end
            ifg_s: begin
                if (cnt_q == IFG_END) begin
                    cnt_d   = '0;
                    state_d = idle_s;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = idle_s;
        endcase
    end

    // No word is consumed in a reset cycle; leftovers are resynced via the misalignment path.
    assign o_data_rd               = rd_c && !reset;
    assign gmii_txd                = txd_q;
    assign gmii_tx_en              = en_q;
    assign gmii_tx_er              = er_q;
    assign ov_tx_ts                = ts_q;
    assign o_ts_valid              = ts_vld_q;
    assign o_pkt_sent_pulse        = sent_q;
    assign o_fifo_underflow_pulse  = uflow_q;
    assign report_gmii_write_state = state_q;

endmodule

// File: doc/gmii_write.md
# gmii_write

Transmit-side counterpart of the network receive path. Drains framed 9-bit words from a show-ahead transmit FIFO and drives the GMII TX interface. Generates preamble/SFD, enforces the inter-frame gap, and timestamps the SFD. It also signals FIFO underflow by terminating the frame on the wire with `gmii_tx_er`.

## Interface
- `PREAMBLE_LEN`, default 7: number of 0x55 bytes before the SFD.
- `IFG_LEN`, default 12: minimum count of `gmii_tx_en`=0 cycles between frames.
- `clk_sys` in 1: system clock, equal to the GMII TX clock.
- `reset` in 1: synchronous, active-high reset.
- `port_enable` in 1: 1 allows new frames to start. Clearing it never truncates a frame in flight.
- `iv_data` in 9: show-ahead FIFO word. Bit 8 marks a boundary (1 on both the head word and the tail word); bits [7:0] are the payload byte.
- `i_data_empty` in 1: FIFO empty. `iv_data` is valid only while this is 0.
- `o_data_rd` out 1: FIFO read strobe. Combinational; consumes the current word at the clock edge.
- `timer` in 19: free-running local time.
- `gmii_txd` out 8: TX data, registered.
- `gmii_tx_en` out 1: TX enable, registered.
- `gmii_tx_er` out 1: TX error, registered.
- `ov_tx_ts` out 19: transmit timestamp.
- `o_ts_valid` out 1: one-cycle pulse marking a new `ov_tx_ts`.
- `o_pkt_sent_pulse` out 1: one-cycle pulse per frame transmitted without error.
- `o_fifo_underflow_pulse` out 1: one-cycle pulse per aborted frame.
- `report_gmii_write_state` out 3: current state encoding.

## Operation
- **States:** `idle_s`=0, `pre_s`=1, `data_s`=2, `discard_s`=3, `ifg_s`=4.
- **Register timing:** every registered output reflects the decision made in the previous cycle.
- **`idle_s`:**
  - Drives en=0, er=0, txd=0.
  - If `port_enable` && !`i_data_empty` && `iv_data[8]`:
    - next cycle drives 0x55 with en=1;
    - the preamble counter is loaded with 1;
    - go to `pre_s`. No read occurs.
  - If !`i_data_empty` && !`iv_data[8]`, the stream is misaligned: go to `discard_s` regardless of `port_enable`.
- **`pre_s`:**
  - While counter < `PREAMBLE_LEN`: drive 0x55 and increment the counter.
  - Otherwise:
    - drive 0xD5;
    - `ov_tx_ts` <= `timer`;
    - pulse `o_ts_valid` (coincident with the SFD on the wire);
    - set the `first` flag;
    - go to `data_s`.
- **`data_s`:**
  - If !`i_data_empty`:
    - assert `o_data_rd`;
    - drive `iv_data[7:0]` with en=1;
    - clear `first`.
    - If `iv_data[8]` && !`first`, the word is the tail: pulse `o_pkt_sent_pulse` together with the tail byte on the wire and go to `ifg_s`.
  - If `i_data_empty`:
    - drive en=1, er=1, txd=0x00 for exactly one cycle;
    - pulse `o_fifo_underflow_pulse`;
    - go to `discard_s`.
- **`discard_s`:**
  - Drives en=0.
  - Asserts `o_data_rd` whenever !`i_data_empty`.
  - When a word with bit 8=1 is consumed, go to `ifg_s`.
  - Holds while the FIFO is empty.
- **`ifg_s`:**
  - Drives en=0.
  - Counts cycles so that exactly `IFG_LEN` en=0 cycles separate the last tail/error byte from the next 0x55, when the next frame is already waiting; then go to `idle_s`.
- **Frame length:** a frame is at least 2 words. A bit-8 word consumed with `first`=1 is always the head.
- **Reset values:** all outputs 0, state `idle_s`, counters 0, `first`=0. Reset mid-frame drops `gmii_tx_en` on the following edge and leaves any FIFO residue to the misalignment path.

## Timing
- Head word visible in idle at cycle 0:
  - 0x55 on cycles 1..7;
  - 0xD5 on cycle 8;
  - head byte read in cycle 8 and on the wire in cycle 9.
- An N-word frame holds `gmii_tx_en` high for `PREAMBLE_LEN`+1+N consecutive cycles.
- `o_data_rd` is asserted only in `data_s` or `discard_s` with !`i_data_empty`. There is never a read on an empty FIFO.
- `ov_tx_ts` holds its value until the next SFD.
- `port_enable` is sampled only in `idle_s`.

## Test plan
- **Single frame:** 64-word frame preloaded, `port_enable`=1.
  - Wire shows 7×0x55, 0xD5, then 64 bytes.
  - en high for 72 cycles, er never high.
  - 64 reads.
  - One `o_pkt_sent_pulse` on the cycle of the last byte.
  - `ov_tx_ts` = `timer` at cycle 7, with `o_ts_valid` on cycle 8.
- **Back-to-back frames:** two 64-word frames queued. Exactly 12 cycles with en=0 between the last byte of frame 1 and the first 0x55 of frame 2.
- **Underflow:** FIFO empties after 20 frame words.
  - Next wire cycle shows en=1, er=1, txd=0x00, and `o_fifo_underflow_pulse`=1.
  - en is then 0.
  - Later-written words up to and including the tail are read with en=0.
  - No `o_pkt_sent_pulse`.
- **Misaligned stream:** 5 words with bit 8=0 followed by one word with bit 8=1. All 6 words are read and `gmii_tx_en` stays 0.
- **`port_enable` control:**
  - `port_enable`=0 with a frame queued: no reads and en=0 for 100 cycles.
  - Set it to 1: the frame starts.
  - Clear it at the 10th data byte: the frame still completes.
- **Mid-frame reset:** `reset` asserted for 1 cycle at the 30th data byte.
  - All outputs are 0 on the next cycle and state is 0.
  - The remaining words are then drained through `discard_s` with en=0.
